// File: rtl/slot_pkg.sv
// +----------------------------------------------------------------------+
// | slot_pkg : shared sizes and types for the dual-dispatch slot tracker |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package slot_pkg;

   localparam int SLOTS = 4;
   localparam int IDX_W = 3;

   typedef logic [IDX_W-1:0] slot_idx_t;
   typedef logic [SLOTS-1:0] slot_vec_t;

   localparam slot_idx_t NONE = 3'd4;

endpackage : slot_pkg

`default_nettype wire

// File: rtl/find_index.sv
// +----------------------------------------------------------------------+
// | find_index : lowest and second-lowest zero bit of a 4-bit vector     |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module find_index
   import slot_pkg::*;
(
   input  logic [SLOTS-1:0] in,
   output logic [IDX_W-1:0] first0,
   output logic [IDX_W-1:0] second0
);

   // Scanning downward leaves the lowest zero in first0; each new hit
   // pushes the previous (higher) one into second0.
   always_comb begin
      first0  = NONE;
      second0 = NONE;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!in[i]) begin
            second0 = first0;
            first0  = slot_idx_t'(i);
         end
      end
   end

endmodule : find_index

`default_nettype wire

// File: rtl/slot_alloc.sv
// +----------------------------------------------------------------------+
// | slot_alloc : 4-entry reservation slot tracker, two in-order grants   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module slot_alloc
   import slot_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       alloc_req,
   input  logic [SLOTS-1:0] free_mask,
   input  logic             flush,
   output logic [1:0]       alloc_gnt,
   output logic [IDX_W-1:0] alloc_idx0,
   output logic [IDX_W-1:0] alloc_idx1,
   output logic [SLOTS-1:0] busy_vec,
   output logic [2:0]       free_count,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             err_double_free
);

   slot_vec_t        r_busy;
   logic [CNT_W-1:0] r_stall;
   logic             r_err;

   slot_idx_t w_first0;
   slot_idx_t w_second0;
   logic      w_gnt0;
   logic      w_gnt1;
   slot_vec_t w_set;
   logic      w_dfree;
   logic      w_stall_inc;
   logic [2:0] w_free_count;

   find_index u_find_index (
      .in      (r_busy),
      .first0  (w_first0),
      .second0 (w_second0)
   );

   assign w_gnt0 = alloc_req[0] & (w_first0 != NONE) & ~flush & ~rst;
   assign w_gnt1 = alloc_req[1] & w_gnt0 & (w_second0 != NONE);

   always_comb begin
      w_set        = '0;
      w_free_count = '0;
      for (int i = 0; i < SLOTS; i++) begin
         w_set[i] = (w_gnt0 && (w_first0 == slot_idx_t'(i))) ||
                    (w_gnt1 && (w_second0 == slot_idx_t'(i)));
         w_free_count = w_free_count + {2'b00, ~r_busy[i]};
      end
   end

   assign w_dfree     = |(free_mask & ~r_busy);
   assign w_stall_inc = alloc_req[0] & ~w_gnt0 & ~flush;

   // Flush keeps the sticky error and the stall count; only rst clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy  <= '0;
         r_stall <= '0;
         r_err   <= 1'b0;
      end else if (flush) begin
         r_busy  <= '0;
      end else begin
         r_busy <= (r_busy & ~free_mask) | w_set;
         if (w_dfree) begin
            r_err <= 1'b1;
         end
         if (w_stall_inc && (r_stall != {CNT_W{1'b1}})) begin
            r_stall <= r_stall + 1'b1;
         end
      end
   end

   assign alloc_gnt       = {w_gnt1, w_gnt0};
   assign alloc_idx0      = w_gnt0 ? w_first0 : NONE;
   assign alloc_idx1      = w_gnt1 ? w_second0 : NONE;
   assign busy_vec        = r_busy;
   assign free_count      = w_free_count;
   assign full            = (r_busy == 4'b1111);
   assign empty           = (r_busy == 4'b0000);
   assign stall_cycles    = r_stall;
   assign err_double_free = r_err;

endmodule : slot_alloc

`default_nettype wire

// File: tb/tb_slot_alloc.sv
// +----------------------------------------------------------------------+
// | tb_slot_alloc : scoreboard bench for slot_alloc with reference model |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_slot_alloc;

   localparam int CW        = 6;
   localparam int STALL_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    alloc_req = '0;
   logic [3:0]    free_mask = '0;
   logic          flush = 1'b0;
   logic [1:0]    alloc_gnt;
   logic [2:0]    alloc_idx0;
   logic [2:0]    alloc_idx1;
   logic [3:0]    busy_vec;
   logic [2:0]    free_count;
   logic          full;
   logic          empty;
   logic [CW-1:0] stall_cycles;
   logic          err_double_free;

   slot_alloc #(.CNT_W(CW)) dut (
      .clk             (clk),
      .rst             (rst),
      .alloc_req       (alloc_req),
      .free_mask       (free_mask),
      .flush           (flush),
      .alloc_gnt       (alloc_gnt),
      .alloc_idx0      (alloc_idx0),
      .alloc_idx1      (alloc_idx1),
      .busy_vec        (busy_vec),
      .free_count      (free_count),
      .full            (full),
      .empty           (empty),
      .stall_cycles    (stall_cycles),
      .err_double_free (err_double_free)
   );

   always #5 clk = ~clk;

   typedef struct {
      int gnt;
      int idx0;
      int idx1;
      int busy;
      int fc;
      int full;
      int empty;
      int stall;
      int err;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   bit   m_busy[4];
   int   m_stall;
   bit   m_err;

   function automatic int busy_word();
      int w = 0;
      for (int i = 0; i < 4; i++) if (m_busy[i]) w |= (1 << i);
      return w;
   endfunction

   function automatic void chk(string name, int act, int exp);
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (vector %0d)", name, act, exp, n_vec);
      end
   endfunction

   // One cycle of stimulus: the expected outputs come from the model state
   // before the edge, then the model steps to the post-edge state.
   task automatic apply(input logic [1:0] req, input logic [3:0] fm,
                        input logic fl, input logic r);
      int   freeq[$];
      exp_t e;
      bit   g0, g1;
      @(posedge clk);
      #1;
      alloc_req = req;
      free_mask = fm;
      flush     = fl;
      rst       = r;
      for (int i = 0; i < 4; i++) if (!m_busy[i]) freeq.push_back(i);
      g0 = req[0] && (freeq.size() > 0) && !fl && !r;
      g1 = req[1] && g0 && (freeq.size() > 1);
      e.gnt   = {30'd0, g1, g0};
      e.idx0  = g0 ? freeq[0] : 4;
      e.idx1  = g1 ? freeq[1] : 4;
      e.busy  = busy_word();
      e.fc    = freeq.size();
      e.full  = (freeq.size() == 0);
      e.empty = (freeq.size() == 4);
      e.stall = m_stall;
      e.err   = m_err;
      sb.push_back(e);
      if (r) begin
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_stall = 0;
         m_err   = 1'b0;
      end else if (fl) begin
         foreach (m_busy[i]) m_busy[i] = 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (fm[i]) begin
               if (m_busy[i]) m_busy[i] = 1'b0;
               else m_err = 1'b1;
            end
         end
         if (g0) m_busy[freeq[0]] = 1'b1;
         if (g1) m_busy[freeq[1]] = 1'b1;
         if (req[0] && !g0 && m_stall < STALL_MAX) m_stall++;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            chk("alloc_gnt",       int'(alloc_gnt),       e.gnt);
            chk("alloc_idx0",      int'(alloc_idx0),      e.idx0);
            chk("alloc_idx1",      int'(alloc_idx1),      e.idx1);
            chk("busy_vec",        int'(busy_vec),        e.busy);
            chk("free_count",      int'(free_count),      e.fc);
            chk("full",            int'(full),            e.full);
            chk("empty",           int'(empty),           e.empty);
            chk("stall_cycles",    int'(stall_cycles),    e.stall);
            chk("err_double_free", int'(err_double_free), e.err);
         end
      end
   end

   initial begin : stimulus
      logic [3:0] fm;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_stall = 0;
      m_err   = 1'b0;
      repeat (2) @(posedge clk);

      apply(2'b11, 4'b0000, 0, 0);   // slots 0,1
      apply(2'b11, 4'b0000, 0, 0);   // slots 2,3
      apply(2'b11, 4'b0000, 0, 0);   // full: stall
      apply(2'b01, 4'b0100, 0, 0);   // free not visible yet
      apply(2'b01, 4'b0000, 0, 0);   // slot 2 again
      apply(2'b00, 4'b1110, 0, 0);   // leave 4'b0001
      apply(2'b10, 4'b0000, 0, 0);   // lane1 alone: no grant
      apply(2'b00, 4'b0010, 0, 0);   // double free
      apply(2'b00, 4'b0000, 1, 0);   // flush keeps error
      apply(2'b00, 4'b0000, 0, 1);   // reset clears it
      apply(2'b11, 4'b0000, 0, 0);
      apply(2'b11, 4'b0000, 0, 0);
      apply(2'b00, 4'b0100, 0, 0);   // busy = 4'b1011
      apply(2'b11, 4'b1111, 1, 0);   // flush: no grants, no stall, no error
      apply(2'b00, 4'b0000, 0, 0);
      apply(2'b11, 4'b0000, 0, 0);
      apply(2'b11, 4'b0000, 0, 0);
      repeat (STALL_MAX + 6) apply(2'b01, 4'b0000, 0, 0);  // saturate and hold
      apply(2'b00, 4'b0000, 0, 1);

      for (int n = 0; n < 3000; n++) begin
         fm = 4'(busy_word()) & 4'($urandom);
         if ($urandom_range(15) == 0) fm = 4'($urandom);
         apply(2'($urandom), fm, ($urandom_range(15) == 0),
               ($urandom_range(63) == 0));
      end

      @(posedge clk);
      #1;
      alloc_req = '0;
      free_mask = '0;
      flush     = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_slot_alloc

`default_nettype wire

// File: doc/slot_alloc.md
Name: slot_alloc

Overview:
- Registered 4-entry slot tracker, reservation-station style, for the dual-dispatch stage.
- Holds the busy vector and feeds it to a find_index instance.
- Consumes that instance's first0/second0 to grant up to two slots per cycle, in order.
- Releases slots on completion and on flush; reports occupancy, stall statistics and a sticky double-free error to the dispatch and debug logic.

Parameters:
- SLOTS, 4, number of tracked slots; fixed at 4 to match find_index input width
- IDX_W, 3, slot index width; values 0-3 are valid, 4 (NONE) means no free slot
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  synchronous, active-high reset
- alloc_req  input  2  per-lane dispatch request; bit0 = older lane0, bit1 = lane1
- free_mask  input  SLOTS  one-hot-or-more mask of slots completing this cycle
- flush  input  1  pipeline flush; releases all slots
- alloc_gnt  output  2  per-lane grant, combinational from registered state and inputs
- alloc_idx0  output  IDX_W  slot index granted to lane0; NONE when not granted
- alloc_idx1  output  IDX_W  slot index granted to lane1; NONE when not granted
- busy_vec  output  SLOTS  registered occupancy, bit i = slot i busy
- free_count  output  3  number of zero bits in busy_vec (0-4)
- full  output  1  busy_vec == 4'b1111
- empty  output  1  busy_vec == 4'b0000
- stall_cycles  output  CNT_W  saturating count of cycles with alloc_req[0]=1 and alloc_gnt[0]=0
- err_double_free  output  1  sticky; set when free_mask hits a non-busy slot

Behaviour:
- Reset (clk edge with rst=1):
  - busy_vec=0, stall_cycles=0, err_double_free=0.
  - Outputs follow: full=0, empty=1, free_count=4.
  - No grants while rst=1.
  - Reset mid-operation discards all occupancy.
- Priority on each edge: rst > flush > normal update.
- Index source:
  - find_index.in = busy_vec.
  - first0 / second0 = lowest / second-lowest index whose busy bit is 0; NONE when that zero does not exist.
- Grants (same cycle, zero latency, from registered busy_vec only):
  - alloc_gnt[0] = alloc_req[0] & (first0 != NONE) & ~flush & ~rst.
  - alloc_gnt[1] = alloc_req[1] & alloc_gnt[0] & (second0 != NONE). Lane1 is never granted ahead of lane0 (in-order dispatch).
  - alloc_req=2'b10 is legal but yields no grant.
  - alloc_idx0 = first0 when alloc_gnt[0], else NONE; alloc_idx1 = second0 when alloc_gnt[1], else NONE.
- Frees take effect at the next edge. A slot freed in cycle N is not grantable until cycle N+1: no same-cycle bypass.
- Next state (normal update): busy_vec <= (busy_vec & ~free_mask) | onehot(alloc_idx0 if granted) | onehot(alloc_idx1 if granted).
- Alloc/free collision: a granted slot is never busy, so it cannot collide with a legal free.
- Double free: any free_mask bit set on a slot where busy_vec is 0 sets err_double_free <= 1.
  - The offending bit is otherwise ignored.
  - The flag stays set until rst; flush does not clear it.
- Flush:
  - busy_vec <= 0 at the edge.
  - Grants are suppressed in the flush cycle; free_mask is ignored that cycle, with no error check.
  - stall_cycles does not increment in a flush cycle.
- stall_cycles:
  - Increments by 1 when alloc_req[0]=1 & alloc_gnt[0]=0 & ~flush.
  - Saturates at 2^CNT_W-1, no wrap.
- full / empty / free_count are combinational from busy_vec.

Decomposition:
- Shared package slot_pkg:
  - SLOTS, IDX_W, NONE = 3'd4
  - typedef slot_idx_t (IDX_W bits)
  - typedef slot_vec_t (SLOTS bits)
- One sub-module: the existing find_index, instantiated once, with its in/first0/second0 ports.
- Popcount, one-hot decode and the counter stay inline.

Test Plan:
- Reset, then alloc_req=2'b11 on empty -> gnt=2'b11, idx0=0, idx1=1; next cycle busy_vec=4'b0011, free_count=2.
- Repeat 2'b11 -> idx0=2, idx1=3, then full=1. Next cycle 2'b11 -> gnt=2'b00, idx0=idx1=4, stall_cycles increments 0->1.
- From 4'b1111, free_mask=4'b0100 with alloc_req=2'b01 in the same cycle -> gnt=0 that cycle. Next cycle 2'b01 -> idx0=2, busy returns to 4'b1111.
- busy=4'b0001, alloc_req=2'b10 -> gnt=2'b00, busy unchanged. Then free_mask=4'b0010 -> err_double_free=1, stays 1 after flush, clears only on rst.
- busy=4'b1011, flush=1 with alloc_req=2'b11 -> gnt=2'b00, stall_cycles unchanged; next cycle busy=0, empty=1.
- Force stall_cycles to 16'hFFFE, hold a stalled request 3 cycles -> value reads FFFF and holds.
